// File: rtl/ddr_ctrl_if_mrank.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | ddr_ctrl_if_mrank: host command decode, config registers and multi-rank refresh   |
// | debt tracking. Optional macro DDR_REF_OVF_EN adds sticky REF_OVF. Rev 1.0         |
// +----------------------------------------------------------------------------------+
module ddr_ctrl_if_mrank #(
  parameter int ASIZE        = 23,
  parameter int NRANK        = 2,
  parameter int MAX_POSTPONE = 8,
  parameter int URGENT_TH    = 6,
  parameter int STAGGER      = 64
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [2:0]       CMD,
  input  logic [ASIZE-1:0] ADDR,
  input  logic             CM_ACK,
  input  logic [NRANK-1:0] REF_ACK,
  output logic             NOP,
  output logic             READA,
  output logic             WRITEA,
  output logic             REFRESH,
  output logic             PRECHARGE,
  output logic             LOAD_MODE,
  output logic [ASIZE-1:0] SADDR,
  output logic [1:0]       SC_CL,
  output logic [1:0]       SC_RC,
  output logic [3:0]       SC_RRD,
  output logic             SC_PM,
  output logic [3:0]       SC_BL,
  output logic [NRANK-1:0] REF_REQ,
  output logic [NRANK-1:0] REF_URGENT,
  output logic             CMD_ACK
`ifdef DDR_REF_OVF_EN
  ,
  output logic [NRANK-1:0] REF_OVF
`endif
);

  localparam int DW = $clog2(MAX_POSTPONE + 1);
  localparam logic [DW-1:0] DEBT_MAX = DW'(MAX_POSTPONE);
  localparam logic [DW-1:0] DEBT_URG = DW'(URGENT_TH);
  localparam logic [DW-1:0] DEBT_ONE = DW'(1);

  logic [5:0]       dec_d, dec_q;
  logic [ASIZE-1:0] saddr_d, saddr_q;
  logic             load_reg1_d, load_reg1_q;
  logic             load_reg2_d, load_reg2_q;
  logic             cmd_ack_d, cmd_ack_q;
  logic [1:0]       sc_cl_d, sc_cl_q, sc_rc_d, sc_rc_q;
  logic [3:0]       sc_rrd_d, sc_rrd_q, sc_bl_d, sc_bl_q;
  logic             sc_pm_d, sc_pm_q;
  logic [15:0]      ref_per_d, ref_per_q;
  logic [15:0]      timer_d [NRANK];
  logic [15:0]      timer_q [NRANK];
  logic [DW-1:0]    debt_d [NRANK];
  logic [DW-1:0]    debt_q [NRANK];
  logic [NRANK-1:0] ref_req_d, ref_req_q, ref_urg_d, ref_urg_q;
  logic [NRANK-1:0] tick;
  logic             ref_en;
`ifdef DDR_REF_OVF_EN
  logic [NRANK-1:0] ovf_d, ovf_q;
`endif

  assign ref_en = (sc_bl_q != 4'd0) && (ref_per_q != 16'd0);

  always_comb begin
    for (int c = 0; c < 6; c++) dec_d[c] = (CMD == 3'(c));
    saddr_d     = ADDR;
    // Internal load strobes toggle while the code is held, so each pulse is acked once.
    load_reg1_d = (CMD == 3'b110) && !load_reg1_q;
    load_reg2_d = (CMD == 3'b111) && !load_reg2_q;
    cmd_ack_d   = (CM_ACK || load_reg1_q || load_reg2_q) && !cmd_ack_q;
    sc_cl_d     = sc_cl_q;
    sc_rc_d     = sc_rc_q;
    sc_rrd_d    = sc_rrd_q;
    sc_pm_d     = sc_pm_q;
    sc_bl_d     = sc_bl_q;
    ref_per_d   = ref_per_q;
    if (load_reg1_q) begin
      sc_cl_d  = saddr_q[1:0];
      sc_rc_d  = saddr_q[3:2];
      sc_rrd_d = saddr_q[7:4];
      sc_pm_d  = saddr_q[8];
      sc_bl_d  = saddr_q[12:9];
    end
    if (load_reg2_q) ref_per_d = saddr_q[15:0];
  end

  always_comb begin
    tick      = '0;
    ref_req_d = '0;
    ref_urg_d = '0;
`ifdef DDR_REF_OVF_EN
    ovf_d     = ovf_q;
`endif
    for (int r = 0; r < NRANK; r++) begin
      timer_d[r] = timer_q[r];
      debt_d[r]  = debt_q[r];
      tick[r]    = ref_en && (timer_q[r] == 16'd0);
      if (load_reg2_q) begin
        // Staggered first load keeps ranks from refreshing in lockstep.
        timer_d[r] = saddr_q[15:0] + 16'(r * STAGGER);
        debt_d[r]  = '0;
`ifdef DDR_REF_OVF_EN
        ovf_d[r]   = 1'b0;
`endif
      end else if (ref_en) begin
        timer_d[r] = tick[r] ? ref_per_q : timer_q[r] - 16'd1;
        if (tick[r] && !REF_ACK[r]) begin
          if (debt_q[r] != DEBT_MAX) debt_d[r] = debt_q[r] + DEBT_ONE;
`ifdef DDR_REF_OVF_EN
          else ovf_d[r] = 1'b1;
`endif
        end else if (!tick[r] && REF_ACK[r] && (debt_q[r] != '0)) begin
          debt_d[r] = debt_q[r] - DEBT_ONE;
        end
      end
      ref_req_d[r] = (debt_d[r] != '0);
      ref_urg_d[r] = (debt_d[r] >= DEBT_URG);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dec_q       <= '0;
      saddr_q     <= '0;
      load_reg1_q <= 1'b0;
      load_reg2_q <= 1'b0;
      cmd_ack_q   <= 1'b0;
      sc_cl_q     <= '0;
      sc_rc_q     <= '0;
      sc_rrd_q    <= '0;
      sc_pm_q     <= 1'b0;
      sc_bl_q     <= '0;
      ref_per_q   <= '0;
      ref_req_q   <= '0;
      ref_urg_q   <= '0;
      for (int r = 0; r < NRANK; r++) begin
        timer_q[r] <= '0;
        debt_q[r]  <= '0;
      end
`ifdef DDR_REF_OVF_EN
      ovf_q       <= '0;
`endif
    end else begin
      dec_q       <= dec_d;
      saddr_q     <= saddr_d;
      load_reg1_q <= load_reg1_d;
      load_reg2_q <= load_reg2_d;
      cmd_ack_q   <= cmd_ack_d;
      sc_cl_q     <= sc_cl_d;
      sc_rc_q     <= sc_rc_d;
      sc_rrd_q    <= sc_rrd_d;
      sc_pm_q     <= sc_pm_d;
      sc_bl_q     <= sc_bl_d;
      ref_per_q   <= ref_per_d;
      ref_req_q   <= ref_req_d;
      ref_urg_q   <= ref_urg_d;
      for (int r = 0; r < NRANK; r++) begin
        timer_q[r] <= timer_d[r];
        debt_q[r]  <= debt_d[r];
      end
`ifdef DDR_REF_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign NOP        = dec_q[0];
  assign READA      = dec_q[1];
  assign WRITEA     = dec_q[2];
  assign REFRESH    = dec_q[3];
  assign PRECHARGE  = dec_q[4];
  assign LOAD_MODE  = dec_q[5];
  assign SADDR      = saddr_q;
  assign SC_CL      = sc_cl_q;
  assign SC_RC      = sc_rc_q;
  assign SC_RRD     = sc_rrd_q;
  assign SC_PM      = sc_pm_q;
  assign SC_BL      = sc_bl_q;
  assign REF_REQ    = ref_req_q;
  assign REF_URGENT = ref_urg_q;
  assign CMD_ACK    = cmd_ack_q;
`ifdef DDR_REF_OVF_EN
  assign REF_OVF    = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_ctrl_if_mrank.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | tb_ddr_ctrl_if_mrank: directed bench for ddr_ctrl_if_mrank (NRANK=2 defaults).    |
// | Rev 1.0                                                                           |
// +----------------------------------------------------------------------------------+
module tb_ddr_ctrl_if_mrank;

  localparam int ASIZE = 23;
  localparam int NRANK = 2;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic [2:0]       CMD;
  logic [ASIZE-1:0] ADDR;
  logic             CM_ACK;
  logic [NRANK-1:0] REF_ACK;
  logic             NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE;
  logic [ASIZE-1:0] SADDR;
  logic [1:0]       SC_CL, SC_RC;
  logic [3:0]       SC_RRD, SC_BL;
  logic             SC_PM;
  logic [NRANK-1:0] REF_REQ, REF_URGENT;
  logic             CMD_ACK;
`ifdef DDR_REF_OVF_EN
  logic [NRANK-1:0] REF_OVF;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ddr_ctrl_if_mrank #(.ASIZE(ASIZE), .NRANK(NRANK)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .CMD(CMD), .ADDR(ADDR), .CM_ACK(CM_ACK),
    .REF_ACK(REF_ACK), .NOP(NOP), .READA(READA), .WRITEA(WRITEA),
    .REFRESH(REFRESH), .PRECHARGE(PRECHARGE), .LOAD_MODE(LOAD_MODE),
    .SADDR(SADDR), .SC_CL(SC_CL), .SC_RC(SC_RC), .SC_RRD(SC_RRD),
    .SC_PM(SC_PM), .SC_BL(SC_BL), .REF_REQ(REF_REQ), .REF_URGENT(REF_URGENT),
    .CMD_ACK(CMD_ACK)
`ifdef DDR_REF_OVF_EN
    , .REF_OVF(REF_OVF)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {LOAD_MODE, PRECHARGE, REFRESH, WRITEA, READA, NOP};
  endfunction

  initial begin
    int ack_cnt;
    int rise0, rise1;
    RESET_N = 1'b0;
    CMD     = 3'b000;
    ADDR    = '0;
    CM_ACK  = 1'b0;
    REF_ACK = '0;
    cyc();
    cyc();
    check_val("rst_strobes", 32'(strobes()), 32'h0);
    check_val("rst_saddr", 32'(SADDR), 32'h0);
    check_val("rst_cfg", {SC_CL, SC_RC, SC_RRD, SC_PM, SC_BL}, 32'h0);
    check_val("rst_ref", {REF_REQ, REF_URGENT, CMD_ACK}, 32'h0);
    RESET_N = 1'b1;

    // Single-cycle READA with address
    CMD = 3'b001; ADDR = 23'h12345;
    cyc();
    CMD = 3'b000; ADDR = '0;
    check_val("reada_strobes", 32'(strobes()), 32'h02);
    check_val("reada_saddr", 32'(SADDR), 32'h12345);
    cyc();
    check_val("reada_gone", 32'(strobes()), 32'h01);

    // Every decoded code gives its own one-hot strobe
    for (int c = 0; c < 6; c++) begin
      CMD = 3'(c); ADDR = 23'(c * 32'h111);
      cyc();
      check_val($sformatf("dec_%0d", c), 32'(strobes()), 32'h1 << c);
      check_val($sformatf("dec_saddr_%0d", c), 32'(SADDR), c * 32'h111);
    end
    CMD = 3'b000;

    // CM_ACK held three cycles gives alternating CMD_ACK
    CM_ACK = 1'b1;
    cyc(); check_val("cmack_1", 32'(CMD_ACK), 32'h1);
    cyc(); check_val("cmack_2", 32'(CMD_ACK), 32'h0);
    cyc(); check_val("cmack_3", 32'(CMD_ACK), 32'h1);
    CM_ACK = 1'b0;
    cyc(); check_val("cmack_4", 32'(CMD_ACK), 32'h0);

    // LOAD_REG1 held 4 cycles: 0x1A5B -> CL=3 RC=2 RRD=5 PM=0 BL=D, two acks
    CMD = 3'b110; ADDR = 23'h01A5B;
    ack_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (i == 3) CMD = 3'b000;
      if (CMD_ACK) ack_cnt++;
    end
    check_val("lr1_acks", 32'(ack_cnt), 32'd2);
    check_val("lr1_cfg", {SC_CL, SC_RC, SC_RRD, SC_PM, SC_BL}, {2'd3, 2'd2, 4'd5, 1'b0, 4'hD});
    check_val("lr1_strobes", 32'(strobes()), 32'h01);

    // 0x901 -> CL=1 RC=0 RRD=0 PM=1 BL=4; refresh still off because REF_PER=0
    CMD = 3'b110; ADDR = 23'h00901;
    cyc();
    CMD = 3'b000;
    cyc();
    check_val("lr1b_cfg", {SC_CL, SC_RC, SC_RRD, SC_PM, SC_BL}, {2'd1, 2'd0, 4'd0, 1'b1, 4'd4});
    for (int i = 0; i < 20; i++) cyc();
    check_val("no_per_req", 32'(REF_REQ), 32'h0);

    // LOAD_REG2 REF_PER=9; k counts edges after the timers are loaded
    CMD = 3'b111; ADDR = 23'd9;
    cyc();
    CMD = 3'b000;
    cyc();
    check_val("lr2_ack", 32'(CMD_ACK), 32'h1);
    rise0 = -1; rise1 = -1;
    for (int k = 1; k <= 138; k++) begin
      REF_ACK[0] = (k == 40) || (k >= 42 && k <= 45) || (k >= 131 && k <= 138);
      REF_ACK[1] = 1'b0;
      cyc();
      if (rise0 < 0 && REF_REQ[0]) rise0 = k;
      if (rise1 < 0 && REF_REQ[1]) rise1 = k;
      case (k)
        39:  check_val("k39_req0_debt3", 32'(REF_REQ[0]), 32'h1);
        43:  check_val("k43_req0_debt1", 32'(REF_REQ[0]), 32'h1);
        44:  check_val("k44_req0_debt0", 32'(REF_REQ[0]), 32'h0);
        46:  check_val("k46_ack_at0", 32'({REF_REQ[0], REF_URGENT[0]}), 32'h0);
        99:  check_val("k99_urg0", 32'(REF_URGENT[0]), 32'h0);
        100: check_val("k100_urg0", 32'(REF_URGENT[0]), 32'h1);
        123: check_val("k123_urg1", 32'(REF_URGENT[1]), 32'h0);
        124: check_val("k124_urg1", 32'(REF_URGENT[1]), 32'h1);
        132: check_val("k132_urg0_debt6", 32'(REF_URGENT[0]), 32'h1);
        133: check_val("k133_urg0_debt5", 32'(REF_URGENT[0]), 32'h0);
        138: check_val("k138_req0_sat", 32'(REF_REQ[0]), 32'h0);
        default: ;
      endcase
`ifdef DDR_REF_OVF_EN
      if (k == 129) check_val("k129_ovf", 32'(REF_OVF), 32'h0);
      if (k == 130) check_val("k130_ovf", 32'(REF_OVF), 32'h1);
      if (k == 138) check_val("k138_ovf", 32'(REF_OVF), 32'h1);
`endif
    end
    REF_ACK = '0;
    check_val("rise0", 32'(rise0), 32'd10);
    check_val("rise1", 32'(rise1), 32'd74);
    check_val("k138_req1", 32'(REF_REQ[1]), 32'h1);

    // LOAD_REG2 again clears all debt and overflow
    CMD = 3'b111; ADDR = 23'd9;
    cyc();
    CMD = 3'b000;
    cyc();
    check_val("clr_req", 32'({REF_REQ, REF_URGENT}), 32'h0);
`ifdef DDR_REF_OVF_EN
    check_val("clr_ovf", 32'(REF_OVF), 32'h0);
`endif
    for (int i = 0; i < 50; i++) cyc();
    check_val("debt5_req", 32'({REF_REQ, REF_URGENT}), 32'h4);

    // Asynchronous reset between edges
    #3;
    RESET_N = 1'b0;
    #1;
    check_val("arst_ref", 32'({REF_REQ, REF_URGENT, CMD_ACK}), 32'h0);
    check_val("arst_cfg", {SC_CL, SC_RC, SC_RRD, SC_PM, SC_BL}, 32'h0);
    check_val("arst_strobes", 32'(strobes()), 32'h0);
    cyc();
    cyc();
    RESET_N = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    check_val("post_rst_req", 32'(REF_REQ), 32'h0);

    // REF_PER alone is not enough while SC_BL is 0
    CMD = 3'b111; ADDR = 23'd4;
    cyc();
    CMD = 3'b000;
    for (int i = 0; i < 20; i++) cyc();
    check_val("bl0_hold", 32'(REF_REQ), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
